oled_frame_streamer: RTL and testbench

//  Initiator side of the pixel-fetch interface: generates pixelAddress for the text/pixel engine, reads

---
 rtl/oled_frame_streamer_pkg.sv | 74 +++++++
 rtl/oled_frame_streamer_spi_byte_tx.sv | 78 +++++++
 rtl/oled_frame_streamer.sv | 170 +++++++++++++++++
 tb/tb_oled_frame_streamer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_pkg
//  Description : Shared types and constants for the SSD1306 frame streamer.
//                Holds the sequencer state encoding, the panel geometry and
//                the power-on command table.
//  Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

  // SSD1306 128x64 geometry: 8 pages of 128 one-byte columns
  localparam int COLS        = 128;
  localparam int PAGES       = 8;
  localparam int FRAME_BYTES = COLS * PAGES;
  localparam int ADDR_W      = 10;

  // Number of bytes in the power-on command table
  localparam int INIT_LEN    = 31;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_RESET_HOLD = 4'd0,
    ST_STARTUP    = 4'd1,
    ST_CMD_LOAD   = 4'd2,
    ST_CMD_SHIFT  = 4'd3,
    ST_PIX_ADDR   = 4'd4,
    ST_PIX_WAIT   = 4'd5,
    ST_PIX_LOAD   = 4'd6,
    ST_PIX_SHIFT  = 4'd7
  } state_e;

  // Power-on command table. The tail selects horizontal addressing over the
  // full 128x8 window so pixel bytes can be streamed frame after frame.
  function automatic logic [7:0] init_table(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;  // display off
      5'd1:    b = 8'hD5;  // clock divide
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;  // multiplex ratio
      5'd4:    b = 8'h3F;
      5'd5:    b = 8'hD3;  // display offset
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;  // start line 0
      5'd8:    b = 8'h8D;  // charge pump
      5'd9:    b = 8'h14;
      5'd10:   b = 8'hA1;  // segment remap
      5'd11:   b = 8'hC8;  // COM scan descending
      5'd12:   b = 8'hDA;  // COM pins
      5'd13:   b = 8'h12;
      5'd14:   b = 8'h81;  // contrast
      5'd15:   b = 8'hCF;
      5'd16:   b = 8'hD9;  // precharge
      5'd17:   b = 8'hF1;
      5'd18:   b = 8'hDB;  // VCOMH deselect
      5'd19:   b = 8'h40;
      5'd20:   b = 8'hA4;  // resume from RAM
      5'd21:   b = 8'hA6;  // normal polarity
      5'd22:   b = 8'h20;  // memory addressing mode
      5'd23:   b = 8'h00;  //   horizontal
      5'd24:   b = 8'h21;  // column range
      5'd25:   b = 8'h00;
      5'd26:   b = 8'h7F;
      5'd27:   b = 8'h22;  // page range
      5'd28:   b = 8'h00;
      5'd29:   b = 8'h07;
      5'd30:   b = 8'hAF;  // display on
      default: b = 8'hE3;  // NOP
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_frame_streamer_spi_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_byte_tx
//  Description : Mode-0 SPI byte shifter, MSB first. Each bit spends CLK_DIV
//                clocks with SCLK low (data settles) then CLK_DIV clocks high.
//                done_o pulses in the last clock of the final high phase so
//                the caller can react on the same edge that SCLK drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       sclk_o,
  output logic       sdin_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [7:0]       sh_q;
  logic             sclk_q;
  logic             sdin_q;
  logic             busy_q;
  logic             phase_end;

  assign phase_end = busy_q && (div_q == DIV_LAST);
  assign done_o    = phase_end && sclk_q && (bit_q == 3'd7);
  assign sclk_o    = sclk_q;
  assign sdin_o    = sdin_q;
  assign busy_o    = busy_q;

  // Half-period timer, SCLK toggling and bit advance on each falling edge
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      div_q  <= '0;
      bit_q  <= 3'd0;
      sh_q   <= 8'd0;
      sclk_q <= 1'b0;
      sdin_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (start_i) begin
        sh_q   <= byte_i;
        sdin_q <= byte_i[7];
        busy_q <= 1'b1;
        div_q  <= '0;
        bit_q  <= 3'd0;
        sclk_q <= 1'b0;
      end
    end else if (phase_end) begin
      div_q <= '0;
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else begin
        sclk_q <= 1'b0;
        if (bit_q == 3'd7) begin
          busy_q <= 1'b0;
        end else begin
          bit_q  <= bit_q + 3'd1;
          sh_q   <= {sh_q[6:0], 1'b0};
          sdin_q <= sh_q[6];
        end
      end
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/oled_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : oled_frame_streamer
//  Description : Resets an SSD1306 panel, sends its init command table, then
//                endlessly fetches frame bytes from the pixel engine by
//                address and streams them over 4-wire SPI.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 1000,
  parameter int STARTUP_WAIT = 100000
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic [7:0]        pixelData,
  output logic [ADDR_W-1:0] pixelAddress,
  output logic              io_sclk,
  output logic              io_sdin,
  output logic              io_cs,
  output logic              io_dc,
  output logic              io_reset,
  output logic              frame_done
);

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [4:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          pix_q, pix_d;
  logic                reset_q, reset_d;
  logic                cs_q, cs_d;
  logic                dc_q, dc_d;
  logic                fdone_q, fdone_d;

  logic                tx_start;
  logic [7:0]          tx_byte;
  logic                tx_busy;
  logic                tx_done;

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .rst_btn (rst_btn),
    .start_i (tx_start),
    .byte_i  (tx_byte),
    .sclk_o  (io_sclk),
    .sdin_o  (io_sdin),
    .busy_o  (tx_busy),
    .done_o  (tx_done)
  );

  assign pixelAddress = addr_q;
  assign io_cs        = cs_q;
  assign io_dc        = dc_q;
  assign io_reset     = reset_q;
  assign frame_done   = fdone_q;

  // State and output registers; async reset aborts any byte in flight
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= ST_RESET_HOLD;
      cnt_q   <= 32'd0;
      idx_q   <= 5'd0;
      addr_q  <= '0;
      pix_q   <= 8'd0;
      reset_q <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      reset_q <= reset_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      fdone_q <= fdone_d;
    end
  end

  // Sequencing: panel reset, startup wait, init table, then pixel fetch loop
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    pix_d    = pix_q;
    reset_d  = reset_q;
    cs_d     = cs_q;
    dc_d     = dc_q;
    fdone_d  = 1'b0;
    tx_start = 1'b0;
    tx_byte  = pix_q;

    case (state_q)
      ST_RESET_HOLD: begin
        if (cnt_q == 32'(RESET_CYCLES - 1)) begin
          cnt_d   = 32'd0;
          reset_d = 1'b1;
          state_d = ST_STARTUP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_STARTUP: begin
        if (cnt_q == 32'(STARTUP_WAIT - 1)) begin
          cnt_d   = 32'd0;
          state_d = ST_CMD_LOAD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_CMD_LOAD: begin
        tx_byte = init_table(idx_q);
        if (!tx_busy) begin
          tx_start = 1'b1;
          cs_d     = 1'b0;
          dc_d     = 1'b0;
          state_d  = ST_CMD_SHIFT;
        end
      end
      ST_CMD_SHIFT: begin
        if (tx_done) begin
          if (idx_q == 5'(INIT_LEN - 1)) begin
            idx_d   = 5'd0;
            state_d = ST_PIX_ADDR;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_CMD_LOAD;
          end
        end
      end
      // Address has just been presented; the engine registers it next edge
      ST_PIX_ADDR: begin
        state_d = ST_PIX_WAIT;
      end
      // Engine output is valid now; capture it on the edge entering PIX_LOAD
      ST_PIX_WAIT: begin
        pix_d   = pixelData;
        dc_d    = 1'b1;
        state_d = ST_PIX_LOAD;
      end
      ST_PIX_LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_PIX_SHIFT;
        end
      end
      // Panel is in horizontal mode, so the frame simply wraps to address 0
      ST_PIX_SHIFT: begin
        if (tx_done) begin
          addr_d  = addr_q + ADDR_W'(1);
          fdone_d = (addr_q == ADDR_W'(FRAME_BYTES - 1));
          state_d = ST_PIX_ADDR;
        end
      end
      default: begin
        state_d = ST_RESET_HOLD;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oled_frame_streamer
//  Description : Scoreboard bench for oled_frame_streamer. Expected SPI bytes
//                are queued by the stimulus; a negedge monitor rebuilds bytes
//                from SCLK/SDIN and compares. A second instance runs with
//                CLK_DIV=1 to check SCLK period and bit order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_frame_streamer;

  localparam int CD = 2;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    logic [9:0] addr;
  } exp_t;

  logic       clk;
  logic       rst_btn;
  logic [7:0] eng_q, eng1_q;
  logic [9:0] pixelAddress, pixelAddress1;
  logic       io_sclk, io_sdin, io_cs, io_dc, io_reset, frame_done;
  logic       io_sclk1, io_sdin1, io_cs1, io_dc1, io_reset1, frame_done1;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         fd_count = 0;
  exp_t       sb[$];

  logic [7:0] INIT_EXP [31] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40,
    8'hA4, 8'hA6, 8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07,
    8'hAF
  };

  oled_frame_streamer #(
    .CLK_DIV      (CD),
    .RESET_CYCLES (4),
    .STARTUP_WAIT (8)
  ) dut (
    .clk          (clk),
    .rst_btn      (rst_btn),
    .pixelData    (eng_q),
    .pixelAddress (pixelAddress),
    .io_sclk      (io_sclk),
    .io_sdin      (io_sdin),
    .io_cs        (io_cs),
    .io_dc        (io_dc),
    .io_reset     (io_reset),
    .frame_done   (frame_done)
  );

  oled_frame_streamer #(
    .CLK_DIV      (1),
    .RESET_CYCLES (4),
    .STARTUP_WAIT (8)
  ) dut1 (
    .clk          (clk),
    .rst_btn      (rst_btn),
    .pixelData    (eng1_q),
    .pixelAddress (pixelAddress1),
    .io_sclk      (io_sclk1),
    .io_sdin      (io_sdin1),
    .io_cs        (io_cs1),
    .io_dc        (io_dc1),
    .io_reset     (io_reset1),
    .frame_done   (frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel engine model: one-clock registered lookup of address[7:0]^0x5A
  always @(posedge clk) begin
    eng_q  <= pixelAddress[7:0] ^ 8'h5A;
    eng1_q <= pixelAddress1[7:0] ^ 8'h5A;
    cyc    <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic dc, input logic [7:0] data, input logic [9:0] addr);
    exp_t e;
    e.dc   = dc;
    e.data = data;
    e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic push_init();
    for (int i = 0; i < 31; i++) push(1'b0, INIT_EXP[i], 10'd0);
  endtask

  task automatic push_pixels(input int count);
    logic [9:0] a;
    for (int k = 0; k < count; k++) begin
      a = 10'(k);
      push(1'b1, a[7:0] ^ 8'h5A, a);
    end
  endtask

  // Monitor: rebuild SPI bytes on SCLK rising edges and check against scoreboard
  logic       prev_sclk = 1'b0;
  logic       prev_fd   = 1'b0;
  logic       prev_pix  = 1'b0;
  logic [7:0] mon_sh    = 8'd0;
  int         mon_nb    = 0;
  int         first_cyc = 0;
  int         last_rise = 0;
  int         last_addr = -1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_btn) begin
      mon_nb    = 0;
      prev_sclk = 1'b0;
      prev_fd   = 1'b0;
      prev_pix  = 1'b0;
    end else begin
      if (io_sclk && !prev_sclk) begin
        if (mon_nb == 0) begin
          first_cyc = cyc;
          if (io_dc && prev_pix) chk("pix_gap", 32'(cyc - last_rise), 32'(2 * CD + 3));
        end
        mon_sh = {mon_sh[6:0], io_sdin};
        mon_nb++;
        if (mon_nb == 8) begin
          chk("byte_len", 32'(cyc - first_cyc), 32'(14 * CD));
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h dc=%0b, expected none", mon_sh, io_dc);
          end else begin
            e = sb.pop_front();
            chk("byte_data", {22'd0, io_cs, io_dc, mon_sh}, {22'd0, 1'b0, e.dc, e.data});
            chk("byte_addr", {22'd0, pixelAddress}, {22'd0, e.addr});
            if (e.dc) last_addr = int'(e.addr);
          end
          last_rise = cyc;
          prev_pix  = io_dc;
          mon_nb    = 0;
        end
      end
      prev_sclk = io_sclk;
      if (frame_done) begin
        fd_count++;
        chk("fd_single", {31'd0, prev_fd}, 32'd0);
        chk("fd_addr_wrap", {22'd0, pixelAddress}, 32'd0);
        chk("fd_after_1023", 32'(last_addr), 32'd1023);
      end
      prev_fd = frame_done;
    end
  end

  // CLK_DIV=1 instance: byte at address 255 is 0xA5; check bit order and period
  initial begin : p_div1
    logic [7:0] bits;
    int         nb;
    int         r0;
    int         r1;
    int         rl;
    logic       ps;
    bits = 8'd0;
    nb   = 0;
    r0   = 0;
    r1   = 0;
    rl   = 0;
    ps   = 1'b0;
    for (int i = 0; i < 20000 && !(rst_btn && pixelAddress1 == 10'd255); i++) @(negedge clk);
    for (int i = 0; i < 200 && nb < 8; i++) begin
      @(negedge clk);
      if (io_sclk1 && !ps) begin
        bits = {bits[6:0], io_sdin1};
        if (nb == 0) r0 = cyc;
        if (nb == 1) r1 = cyc;
        rl = cyc;
        nb++;
      end
      ps = io_sclk1;
    end
    chk("cd1_bit_count", 32'(nb), 32'd8);
    chk("cd1_bits_msb_first", {24'd0, bits}, 32'h0000_00A5);
    chk("cd1_sclk_period", 32'(r1 - r0), 32'd2);
    chk("cd1_byte_span", 32'(rl - r0), 32'd14);
  end

  // Main stimulus
  initial begin : p_stim
    logic reached;
    rst_btn = 1'b0;
    push_init();
    push_pixels(1024);
    push_pixels(300);
    repeat (3) @(negedge clk);
    chk("rst_outputs", {16'd0, io_reset, io_cs, io_sclk, io_sdin, io_dc, frame_done, pixelAddress},
        32'h0000_4000);

    rst_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("io_reset_hold", {31'd0, io_reset}, 32'd0);
    @(negedge clk);
    chk("io_reset_rise", {31'd0, io_reset}, 32'd1);

    reached = 1'b0;
    for (int i = 0; i < 60000 && !reached; i++) begin
      @(negedge clk);
      if (fd_count == 1 && pixelAddress == 10'd300) reached = 1'b1;
    end
    chk("reach_frame2_addr300", {31'd0, reached}, 32'd1);

    if (reached) begin
      repeat (10) @(negedge clk);
      chk("sb_drained_before_reset", 32'(sb.size()), 32'd0);
      chk("in_pix_shift_at_300", {22'd0, pixelAddress}, 32'd300);
      rst_btn = 1'b0;
      #1;
      chk("rst_mid_outputs", {16'd0, io_reset, io_cs, io_sclk, io_sdin, io_dc, frame_done, pixelAddress},
          32'h0000_4000);
      sb.delete();
      push_init();
      push_pixels(4);
      repeat (2) @(negedge clk);
      rst_btn = 1'b1;
      for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
      chk("restart_drained", 32'(sb.size()), 32'd0);
      chk("frame_done_count", 32'(fd_count), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
